// File: rtl/axis_insert_header_arb.sv
// axis_insert_header_arb
//
// Round-robin arbiter in front of a header inserter. One source pair at a time
// is granted: its header beat goes out on m00, then its payload stream goes out
// on m01. The grant is released when the payload beat carrying tlast is
// accepted. Both data paths are combinational muxes from the granted source, so
// there is no buffering and no added latency on the data.
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   s_hdr_tvalid/tdata/tkeep   per-source header inputs (source i at slice i)
//   s_hdr_tready               per-source header ready
//   s_dat_tvalid/tdata/tkeep/tlast  per-source payload inputs
//   s_dat_tready               per-source payload ready
//   m00_axis_*                 header channel to the inserter
//   m01_axis_*                 payload channel to the inserter
//   grant                      one-hot current owner, 0 when idle
//   busy                       high while a packet is in flight (HDR or DATA)
module axis_insert_header_arb #(
    parameter int NUM_SRC      = 2,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [NUM_SRC-1:0]                s_hdr_tvalid,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_hdr_tdata,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_hdr_tkeep,
    output logic [NUM_SRC-1:0]                s_hdr_tready,

    input  logic [NUM_SRC-1:0]                s_dat_tvalid,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_dat_tdata,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_dat_tkeep,
    input  logic [NUM_SRC-1:0]                s_dat_tlast,
    output logic [NUM_SRC-1:0]                s_dat_tready,

    output logic                              m00_axis_tvalid,
    output logic [DATA_WD-1:0]                m00_axis_tdata,
    output logic [DATA_BYTE_WD-1:0]           m00_axis_tkeep,
    input  logic                              m00_axis_tready,

    output logic                              m01_axis_tvalid,
    output logic [DATA_WD-1:0]                m01_axis_tdata,
    output logic [DATA_BYTE_WD-1:0]           m01_axis_tkeep,
    output logic                              m01_axis_tlast,
    input  logic                              m01_axis_tready,

    output logic [NUM_SRC-1:0]                grant,
    output logic                              busy
);

    localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    logic [RR_W-1:0] rr;
    logic [RR_W-1:0] sel;

    logic [RR_W-1:0] pick_idx;
    logic            pick_vld;
    logic            hdr_hs;
    logic            dat_last_hs;

    // Round-robin search: walk offsets from the highest down so that the
    // smallest offset from rr with a pending header is the one kept.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (s_hdr_tvalid[RR_W'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = RR_W'(j);
            end
        end
    end

    // Combinational muxes from the granted source; valid/ready/tlast are
    // gated by state so nothing leaks out of the wrong phase.
    always_comb begin
        m00_axis_tdata  = s_hdr_tdata[sel*DATA_WD +: DATA_WD];
        m00_axis_tkeep  = s_hdr_tkeep[sel*DATA_BYTE_WD +: DATA_BYTE_WD];
        m01_axis_tdata  = s_dat_tdata[sel*DATA_WD +: DATA_WD];
        m01_axis_tkeep  = s_dat_tkeep[sel*DATA_BYTE_WD +: DATA_BYTE_WD];
        m00_axis_tvalid = 1'b0;
        m01_axis_tvalid = 1'b0;
        m01_axis_tlast  = 1'b0;
        s_hdr_tready    = '0;
        s_dat_tready    = '0;
        if (state == HDR) begin
            m00_axis_tvalid   = s_hdr_tvalid[sel];
            s_hdr_tready[sel] = m00_axis_tready;
        end
        if (state == DATA) begin
            m01_axis_tvalid   = s_dat_tvalid[sel];
            m01_axis_tlast    = s_dat_tlast[sel];
            s_dat_tready[sel] = m01_axis_tready;
        end
    end

    assign hdr_hs      = m00_axis_tvalid && m00_axis_tready;
    assign dat_last_hs = m01_axis_tvalid && m01_axis_tready && m01_axis_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr    <= '0;
            sel   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel   <= pick_idx;
                        grant <= NUM_SRC'(1) << pick_idx;
                        busy  <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_hs) state <= DATA;
                end
                DATA: begin
                    if (dat_last_hs) begin
                        // Explicit wrap: NUM_SRC need not be a power of two.
                        rr    <= (sel == RR_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_insert_header_arb.sv
module tb_axis_insert_header_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_hdr_tvalid;
    logic [N*DW-1:0]   s_hdr_tdata;
    logic [N*KW-1:0]   s_hdr_tkeep;
    logic [N-1:0]      s_hdr_tready;
    logic [N-1:0]      s_dat_tvalid;
    logic [N*DW-1:0]   s_dat_tdata;
    logic [N*KW-1:0]   s_dat_tkeep;
    logic [N-1:0]      s_dat_tlast;
    logic [N-1:0]      s_dat_tready;
    logic              m00_axis_tvalid;
    logic [DW-1:0]     m00_axis_tdata;
    logic [KW-1:0]     m00_axis_tkeep;
    logic              m00_axis_tready;
    logic              m01_axis_tvalid;
    logic [DW-1:0]     m01_axis_tdata;
    logic [KW-1:0]     m01_axis_tkeep;
    logic              m01_axis_tlast;
    logic              m01_axis_tready;
    logic [N-1:0]      grant;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axis_insert_header_arb #(.NUM_SRC(N), .DATA_WD(DW), .DATA_BYTE_WD(KW)) dut (
        .clk(clk), .rst(rst),
        .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tdata(s_hdr_tdata),
        .s_hdr_tkeep(s_hdr_tkeep), .s_hdr_tready(s_hdr_tready),
        .s_dat_tvalid(s_dat_tvalid), .s_dat_tdata(s_dat_tdata),
        .s_dat_tkeep(s_dat_tkeep), .s_dat_tlast(s_dat_tlast),
        .s_dat_tready(s_dat_tready),
        .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tkeep(m00_axis_tkeep), .m00_axis_tready(m00_axis_tready),
        .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tdata(m01_axis_tdata),
        .m01_axis_tkeep(m01_axis_tkeep), .m01_axis_tlast(m01_axis_tlast),
        .m01_axis_tready(m01_axis_tready),
        .grant(grant), .busy(busy)
    );

    // One record = inputs held for one clock cycle + outputs expected in it.
    typedef struct {
        logic [3:0] hv, dv, dl;
        logic       m00r, m01r;
        logic [7:0] beat;
        logic [3:0] e_grant;
        logic       e_busy, e_m00v, e_m01v, e_last;
        logic [3:0] e_hrdy, e_drdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] hv, dv, dl, input logic m00r, m01r,
                               input logic [7:0] beat, input logic [3:0] e_grant,
                               input logic e_busy, e_m00v, e_m01v, e_last,
                               input logic [3:0] e_hrdy, e_drdy);
        vec_t r;
        r.hv = hv; r.dv = dv; r.dl = dl; r.m00r = m00r; r.m01r = m01r; r.beat = beat;
        r.e_grant = e_grant; r.e_busy = e_busy; r.e_m00v = e_m00v; r.e_m01v = e_m01v;
        r.e_last = e_last; r.e_hrdy = e_hrdy; r.e_drdy = e_drdy;
        return r;
    endfunction

    function automatic logic [31:0] hdr_word(input int i);
        if (i == 0) return 32'hAABBCCDD;
        return 32'h1100_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] dat_word(input int i, input logic [7:0] b);
        return {8'hD0 | 8'(i), 16'h0000, b};
    endfunction

    function automatic logic [3:0] hdr_keep(input int i);
        return 4'(15 - i);
    endfunction

    function automatic logic [3:0] dat_keep(input int i);
        return 4'(8 + i);
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic drive(input vec_t r, input logic r_rst);
        rst             = r_rst;
        s_hdr_tvalid    = r.hv;
        s_dat_tvalid    = r.dv;
        s_dat_tlast     = r.dl;
        m00_axis_tready = r.m00r;
        m01_axis_tready = r.m01r;
        for (int i = 0; i < N; i++) begin
            s_hdr_tdata[i*DW +: DW] = hdr_word(i);
            s_hdr_tkeep[i*KW +: KW] = hdr_keep(i);
            s_dat_tdata[i*DW +: DW] = dat_word(i, r.beat);
            s_dat_tkeep[i*KW +: KW] = dat_keep(i);
        end
    endtask

    task automatic check(input vec_t r, input int row);
        int src;
        src = onehot_idx(r.e_grant);
        chk("grant",      row, 32'(grant),           32'(r.e_grant));
        chk("busy",       row, 32'(busy),            32'(r.e_busy));
        chk("m00_tvalid", row, 32'(m00_axis_tvalid), 32'(r.e_m00v));
        chk("m01_tvalid", row, 32'(m01_axis_tvalid), 32'(r.e_m01v));
        chk("m01_tlast",  row, 32'(m01_axis_tlast),  32'(r.e_last));
        chk("hdr_tready", row, 32'(s_hdr_tready),    32'(r.e_hrdy));
        chk("dat_tready", row, 32'(s_dat_tready),    32'(r.e_drdy));
        if (r.e_m00v) begin
            chk("m00_tdata", row, m00_axis_tdata,       hdr_word(src));
            chk("m00_tkeep", row, 32'(m00_axis_tkeep),  32'(hdr_keep(src)));
        end
        if (r.e_m01v) begin
            chk("m01_tdata", row, m01_axis_tdata,       dat_word(src, r.beat));
            chk("m01_tkeep", row, 32'(m01_axis_tkeep),  32'(dat_keep(src)));
        end
    endtask

    // Apply one record for a full cycle and check outputs mid-cycle.
    task automatic step(input vec_t r, input logic r_rst, input int row);
        @(posedge clk);
        #1;
        drive(r, r_rst);
        @(negedge clk);
        check(r, row);
    endtask

    initial begin
        vec_t z;
        z = v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'd0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0);

        // Reset state, with requests present so gating is exercised.
        drive(z, 1'b1);
        s_hdr_tvalid = 4'hF;
        s_dat_tvalid = 4'hF;
        s_dat_tlast  = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(v(4'hF, 4'hF, 4'hF, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0), 0);
        @(posedge clk);
        #1;
        drive(z, 1'b0);

        // Single source 0: 3-beat payload; early payload beat stalled in HDR.
        tbl.push_back(v(4'h1, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(v(4'h1, 4'h1, 4'h0, 1, 1, 0, 4'h1, 1, 1, 0, 0, 4'h1, 4'h0));
        tbl.push_back(v(4'h0, 4'h1, 4'h0, 1, 1, 1, 4'h1, 1, 0, 1, 0, 4'h0, 4'h1));
        tbl.push_back(v(4'h0, 4'h1, 4'h0, 1, 1, 2, 4'h1, 1, 0, 1, 0, 4'h0, 4'h1));
        tbl.push_back(v(4'h0, 4'h1, 4'h1, 1, 1, 3, 4'h1, 1, 0, 1, 1, 4'h0, 4'h1));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
        // Contention, rr=1: order 1,0,1,0 with one IDLE cycle between packets.
        for (int p = 0; p < 4; p++) begin
            logic [3:0] g;
            g = (p % 2 == 0) ? 4'h2 : 4'h1;
            tbl.push_back(v(4'h3, 4'h3, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
            tbl.push_back(v(4'h3, 4'h3, 4'h0, 1, 1, 0, g, 1, 1, 0, 0, g, 4'h0));
            tbl.push_back(v(4'h3, 4'h3, 4'h0, 1, 1, 1, g, 1, 0, 1, 0, 4'h0, g));
            tbl.push_back(v(4'h3, 4'h3, 4'h3, 1, 1, 2, g, 1, 0, 1, 1, 4'h0, g));
        end
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
        // Backpressure on source 1 (rr=1): m00 stalls 3 cycles, m01 toggles.
        tbl.push_back(v(4'h2, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(4'h2, 4'h0, 4'h0, 0, 1, 0, 4'h2, 1, 1, 0, 0, 4'h0, 4'h0));
        tbl.push_back(v(4'h2, 4'h0, 4'h0, 1, 0, 0, 4'h2, 1, 1, 0, 0, 4'h2, 4'h0));
        tbl.push_back(v(4'h0, 4'h2, 4'h0, 1, 0, 1, 4'h2, 1, 0, 1, 0, 4'h0, 4'h0));
        tbl.push_back(v(4'h0, 4'h2, 4'h0, 1, 1, 1, 4'h2, 1, 0, 1, 0, 4'h0, 4'h2));
        tbl.push_back(v(4'h0, 4'h2, 4'h2, 1, 0, 2, 4'h2, 1, 0, 1, 1, 4'h0, 4'h0));
        tbl.push_back(v(4'h0, 4'h2, 4'h2, 1, 1, 2, 4'h2, 1, 0, 1, 1, 4'h0, 4'h2));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
        // Wrap and skip, rr=2, sources 1 and 3, single-beat packets: 3,1,3.
        for (int p = 0; p < 3; p++) begin
            logic [3:0] g;
            g = (p == 1) ? 4'h2 : 4'h8;
            tbl.push_back(v(4'hA, 4'hA, 4'hA, 1, 1, 5, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));
            tbl.push_back(v(4'hA, 4'hA, 4'hA, 1, 1, 5, g, 1, 1, 0, 0, g, 4'h0));
            tbl.push_back(v(4'hA, 4'hA, 4'hA, 1, 1, 5, g, 1, 0, 1, 1, 4'h0, g));
        end
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0));

        for (int r = 0; r < tbl.size(); r++) step(tbl[r], 1'b0, r + 1);

        // Reset mid-packet. First move rr to 2 with a one-beat packet from 1.
        step(v(4'h2, 4'h2, 4'h2, 1, 1, 7, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0), 1'b0, 200);
        step(v(4'h2, 4'h2, 4'h2, 1, 1, 7, 4'h2, 1, 1, 0, 0, 4'h2, 4'h0), 1'b0, 201);
        step(v(4'h2, 4'h2, 4'h2, 1, 1, 7, 4'h2, 1, 0, 1, 1, 4'h0, 4'h2), 1'b0, 202);
        // Source 2 four-beat packet, rst asserted during beat 2.
        step(v(4'h4, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0), 1'b0, 203);
        step(v(4'h4, 4'h0, 4'h0, 1, 1, 0, 4'h4, 1, 1, 0, 0, 4'h4, 4'h0), 1'b0, 204);
        step(v(4'h0, 4'h4, 4'h0, 1, 1, 1, 4'h4, 1, 0, 1, 0, 4'h0, 4'h4), 1'b0, 205);
        step(v(4'h0, 4'h4, 4'h0, 1, 1, 2, 4'h4, 1, 0, 1, 0, 4'h0, 4'h4), 1'b1, 206);
        // After reset: idle outputs; sources 0 and 2 request, rr=0 picks 0.
        step(v(4'h5, 4'h4, 4'h0, 1, 1, 3, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0), 1'b0, 207);
        step(v(4'h5, 4'h0, 4'h0, 1, 1, 0, 4'h1, 1, 1, 0, 0, 4'h1, 4'h0), 1'b0, 208);
        step(v(4'h4, 4'h1, 4'h1, 1, 1, 9, 4'h1, 1, 0, 1, 1, 4'h0, 4'h1), 1'b0, 209);
        step(v(4'h4, 4'h0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0), 1'b0, 210);
        step(v(4'h4, 4'h0, 4'h0, 1, 1, 0, 4'h4, 1, 1, 0, 0, 4'h4, 4'h0), 1'b0, 211);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_insert_header_arb.md
# axis_insert_header_arb

Round-robin arbiter that shares one header-insertion datapath between NUM_SRC independent (header, payload) source pairs. It grants one source at a time. It forwards that source's header beat to the inserter's header channel, then its payload stream to the inserter's data channel. The grant is held until the payload beat carrying tlast is accepted. The block sits directly upstream of the header inserter, and its master ports connect one-to-one to the inserter's s00/s01 slave ports.

## Interface
Parameters:
- NUM_SRC, 2: number of source pairs (2..8).
- DATA_WD, 32: payload/header data width.
- DATA_BYTE_WD, DATA_WD/8: keep width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset; synchronous and active-high.
- s_hdr_tvalid  in  NUM_SRC  header valid per source.
- s_hdr_tdata  in  NUM_SRC*DATA_WD  header data; source i at [i*DATA_WD +: DATA_WD].
- s_hdr_tkeep  in  NUM_SRC*DATA_BYTE_WD  header keep; source i at [i*DATA_BYTE_WD +: DATA_BYTE_WD].
- s_hdr_tready  out  NUM_SRC  header ready per source.
- s_dat_tvalid  in  NUM_SRC  payload valid per source.
- s_dat_tdata  in  NUM_SRC*DATA_WD  payload data; same packing as s_hdr_tdata.
- s_dat_tkeep  in  NUM_SRC*DATA_BYTE_WD  payload keep; same packing as s_hdr_tkeep.
- s_dat_tlast  in  NUM_SRC  payload last per source.
- s_dat_tready  out  NUM_SRC  payload ready per source.
- m00_axis_tvalid/tdata/tkeep  out  1/DATA_WD/DATA_BYTE_WD  header to inserter.
- m00_axis_tready  in  1  header ready from inserter.
- m01_axis_tvalid/tdata/tkeep/tlast  out  1/DATA_WD/DATA_BYTE_WD/1  payload to inserter.
- m01_axis_tready  in  1  payload ready from inserter.
- grant  out  NUM_SRC  one-hot current owner; 0 in IDLE.
- busy  out  1  high in HDR or DATA.

## Operation
State machine: IDLE, HDR, DATA.

IDLE:
- Request vector is s_hdr_tvalid.
- If any bit is set, select the first set bit searching upward from pointer rr, wrapping modulo NUM_SRC.
- Register the selection as sel (one-hot grant) and go to HDR.
- Payload tvalid alone never raises a request.

HDR:
- Header channel muxes combinationally from sel: m00_axis_tvalid = s_hdr_tvalid[sel]; m00 tdata/tkeep = source sel's fields.
- s_hdr_tready[sel] = m00_axis_tready.
- On header handshake, go to DATA.

DATA:
- Payload channel muxes combinationally from sel: m01_axis_tvalid = s_dat_tvalid[sel]; m01 tdata/tkeep/tlast = source sel's fields.
- s_dat_tready[sel] = m01_axis_tready.
- On a handshake with tlast=1: go to IDLE, set rr = (sel+1) mod NUM_SRC, clear grant.

Gating rules:
- All non-selected readys are 0, and all readys are 0 in IDLE.
- m00 valid is 0 outside HDR; m01 valid is 0 outside DATA.
- Outputs are never driven from non-selected sources.
- tdata/tkeep on an inactive master port are don't-care; the bench must not check them.

rr pointer:
- Width is $clog2(NUM_SRC), minimum 1.
- Wrap is explicit: sel==NUM_SRC-1 gives rr=0.

Boundary and error cases:
- A source dropping header tvalid after grant is an upstream protocol violation. The block stays in HDR until it is seen again; no timeout.
- A payload beat of the selected source arriving during HDR is stalled (ready 0).
- A payload with tlast on its first beat is legal: one DATA beat, then IDLE.
- Reset asserted mid-packet: next cycle is IDLE, rr=0, grant=0. A partially transferred packet is abandoned; downstream recovery is the inserter's own reset.

## Timing
Reset values:
- All s_*_tready 0; m00/m01 tvalid 0; m01_axis_tlast 0; grant 0; busy 0.
- Internal state: state IDLE, rr 0.

Latency and throughput:
- Request seen in IDLE at cycle N gives grant/busy high and m00 valid at cycle N+1.
- Header and payload muxes are combinational, so 0-cycle latency through the block and no buffering.
- Per packet: 1 arbitration cycle + header handshake cycles + payload beats. Back-to-back packets from any sources are separated by exactly one IDLE cycle.
- Full throughput within a packet: 1 beat/cycle when source and sink are both ready.

Fairness:
- With all NUM_SRC sources continuously requesting, grants cycle 0,1,…,NUM_SRC-1,0.
- Worst-case wait is NUM_SRC-1 packets.

## Test plan
- Single source: NUM_SRC=2, source 0 sends header 0xAABBCCDD and payload 3 beats (tlast on beat 3), sinks always ready. Response: grant=01 one cycle after request; m00 beat 0xAABBCCDD; m01 3 beats with tlast on beat 3; busy drops next cycle; rr=1.
- Contention: both sources request every cycle, 2-beat payloads. Response: packet order src0, src1, src0, src1; exactly one IDLE cycle between packets; s_*_tready of the idle source is never 1.
- Backpressure: m00_axis_tready low 3 cycles, then m01_axis_tready toggling. Response: m00/m01 data held stable while valid && !ready; no beat lost or duplicated; grant stable until tlast handshake.
- Early payload: source 1 payload valid 2 cycles before its header. Response: s_dat_tready[1]=0 until the header handshake completes; payload then forwarded unchanged.
- Wrap and skip: NUM_SRC=4, rr=3, only sources 1 and 3 requesting. Response: grant order 3, 1, 3; rr wraps 3→0 correctly.
- Reset mid-packet: rst high during beat 2 of 4. Response: next cycle all readys 0, m01 valid 0, grant 0, rr 0; a new request is granted normally after rst deasserts.
